local_memory_arbiter: RTL
=========================

# local_memory_arbiter

Parametrised successor to the ExperiarCore local memory interface. It arbitrates two 32-bit requesters, the core memory path and the Wishbone slave path, onto BANK_COUNT dual-port SRAM macros (port 0 read/write, port 1 read-only). It adds a configurable bank count, round-robin arbitration on the shared port, out-of-range handling, and an optional same-cycle write-to-read forwarding path. It sits between MemoryController/WB_SRAMInterface and the SRAM macros.

## Interface
Parameters:
- SRAM_ADDRESS_SIZE, 9, word address width of one SRAM bank
- BANK_COUNT, 2, number of SRAM banks; power of two, 1..8

Ports (requester prefix `core`/`wb`, each with the same set of signals):
- clk  in  1  single clock; also driven to clk0/clk1
- rst_n  in  1  synchronous, active-low reset
- coreAddress, wbAddress  in  24  byte address
- coreByteSelect, wbByteSelect  in  4  byte lanes
- coreWriteEnable, wbWriteEnable  in  1  write request
- coreReadEnable, wbReadEnable  in  1  read request
- coreDataWrite, wbDataWrite  in  32  write data
- coreDataRead, wbDataRead  out  32  read data
- coreBusy, wbBusy  out  1  request not yet complete
- clk0  out  1  port 0 clock (= clk)
- csb0  out  BANK_COUNT  port 0 chip select, active-low
- web0  out  1  port 0 write enable, active-low
- wmask0  out  4  port 0 write mask
- addr0  out  SRAM_ADDRESS_SIZE  port 0 word address
- din0  out  32  port 0 write data
- dout0  in  32*BANK_COUNT  port 0 read data, bank b in bits [32b+31:32b]
- clk1  out  1  port 1 clock (= clk)
- csb1  out  BANK_COUNT  port 1 chip select, active-low
- addr1  out  SRAM_ADDRESS_SIZE  port 1 word address
- dout1  in  32*BANK_COUNT  port 1 read data

## Operation
- Address decode:
  - word = addr[SRAM_ADDRESS_SIZE+1:2]
  - bank = next log2(BANK_COUNT) bits
  - any higher bit set makes the access out of range
- Port routing:
  - Port 1 serves core reads only.
  - Port 0 serves core writes, wb reads and wb writes.
  - Read and write asserted together on one requester is treated as a write.
- Each port has its own FSM with states IDLE and READ.
  - IDLE + granted read: assert csb of the selected bank and drive addr; busy=1; register bank index; next state READ.
  - READ: dataRead = selected bank slice of dout; busy=0; return to IDLE. No new access starts on that port in READ.
  - IDLE + granted write: csb/web0 low, wmask0=byteSelect, din0=data; busy=0 in the same cycle.
- Port 0 arbitration, applied only in IDLE:
  - One requester pending: it is granted.
  - Core write and wb access both pending: the round-robin pointer decides. The loser sees busy=1.
  - The pointer flips to the other requester after every contested grant and is unchanged otherwise.
- Out of range:
  - No csb asserted.
  - Write: completes in one cycle, data dropped.
  - Read: follows the normal two-cycle sequence, dataRead=32'h0.
- dataRead holds its last value while IDLE.
- Collision case: a core read on port 1 and a granted port-0 write target the same bank+word in the same cycle. Handling is set by Configuration.
- Reset (rst_n low at a clock edge):
  - Both FSMs to IDLE, pointer to core.
  - dataRead=0, csb0/csb1 all ones, web0=1, wmask0=0, addr0/addr1=0, din0=0.
  - busy=1 on both requesters while rst_n is low.
  - An in-flight read is abandoned and its data is never returned.

## Timing
- Read latency 2 cycles:
  - Request seen at edge N; busy=1 during cycle N.
  - Data valid and busy=0 during cycle N+1.
  - Earliest next access on the same port: N+2.
- Write latency 1 cycle when granted; each cycle lost in arbitration adds one cycle.
- Requesters hold address, data and enables stable while busy=1.
- Core read and wb access proceed concurrently on separate ports.
- A wb read blocks core writes for 2 cycles.

## Configuration
- LOCAL_MEMORY_WRITE_FORWARD_EN defined:
  - On a collision the core read issues normally.
  - At N+1 coreDataRead takes written bytes from the registered write data (per registered wmask) and the remaining bytes from dout1.
- LOCAL_MEMORY_WRITE_FORWARD_EN undefined:
  - On a collision csb1 stays high and coreBusy stays 1.
  - The read retries at N+1, giving 3-cycle total latency.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with requests asserted -> csb0/csb1 all ones, web0=1, both busy=1, dataRead=0; after release, first core read at addr 0x000004 -> csb1=2'b10, addr1=1, data at N+1.
- Bank decode (BANK_COUNT=2, SRAM_ADDRESS_SIZE=9): core read 0x000804 -> csb1=2'b01, addr1=1, coreDataRead=dout1[63:32]; read 0x001000 -> no csb, data 0, busy released at N+1.
- Contention: core write and wb write both pending for 4 cycles -> grants alternate core, wb, core, wb, starting with core after reset.
- wb read 0x000010 blocks a core write issued one cycle later -> core write completes at N+2, csb0 low for exactly one cycle of each access.
- Collision: write 0xAABBCCDD, sel 4'b0011, to the word being read (old value 0x11223344) -> with macro, 0x1122CCDD at N+1; without, busy until N+2, then 0x1122CCDD from SRAM.
- Reset mid-read: assert rst_n=0 at cycle N+1 of a read -> dataRead=0, FSM IDLE, no stale data after release.

Source files
------------

// File: rtl/local_memory_arbiter.sv
// Arbitrates the core and Wishbone requesters onto BANK_COUNT dual-port SRAM banks.
// Optional same-cycle write-to-read forwarding is enabled by defining LOCAL_MEMORY_WRITE_FORWARD_EN.
module local_memory_arbiter #(
  parameter int unsigned SRAM_ADDRESS_SIZE = 9,
  parameter int unsigned BANK_COUNT = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [23:0]                     coreAddress,
  input  logic [3:0]                      coreByteSelect,
  input  logic                            coreWriteEnable,
  input  logic                            coreReadEnable,
  input  logic [31:0]                     coreDataWrite,
  output logic [31:0]                     coreDataRead,
  output logic                            coreBusy,
  input  logic [23:0]                     wbAddress,
  input  logic [3:0]                      wbByteSelect,
  input  logic                            wbWriteEnable,
  input  logic                            wbReadEnable,
  input  logic [31:0]                     wbDataWrite,
  output logic [31:0]                     wbDataRead,
  output logic                            wbBusy,
  output logic                            clk0,
  output logic [BANK_COUNT-1:0]           csb0,
  output logic                            web0,
  output logic [3:0]                      wmask0,
  output logic [SRAM_ADDRESS_SIZE-1:0]    addr0,
  output logic [31:0]                     din0,
  input  logic [32*BANK_COUNT-1:0]        dout0,
  output logic                            clk1,
  output logic [BANK_COUNT-1:0]           csb1,
  output logic [SRAM_ADDRESS_SIZE-1:0]    addr1,
  input  logic [32*BANK_COUNT-1:0]        dout1
);

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BANK_W     = $clog2(BANK_COUNT);
  localparam int unsigned BANK_IDX_W = (BANK_W > 0) ? BANK_W : 1;

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} portState_t;

  portState_t port0State, port0Next, port1State, port1Next;
  logic rrPointer, rrNext;  // 0: core wins the next contested grant, 1: wb
  logic [BANK_IDX_W-1:0] bank0Reg, bank0Next, bank1Reg, bank1Next;
  logic oor0Reg, oor0Next, oor1Reg, oor1Next;
  logic [DATA_W-1:0] coreHeld, coreHeldNext, wbHeld, wbHeldNext, core1Data;

  logic [BANK_IDX_W-1:0] coreBank, wbBank;
  logic [SRAM_ADDRESS_SIZE-1:0] coreWord, wbWord;
  logic coreOutOfRange, wbOutOfRange;
  logic coreWriteReq, coreReadReq, wbReq;
  logic port0Idle, port1Idle, grantCore, grantWb, contested, collision, readBlocked;

`ifdef LOCAL_MEMORY_WRITE_FORWARD_EN
  logic fwdValid, fwdValidNext;
  logic [3:0] fwdMask, fwdMaskNext;
  logic [DATA_W-1:0] fwdData, fwdDataNext;
`endif

  function automatic logic [BANK_IDX_W-1:0] bankOf(input logic [ADDR_W-1:0] a);
    return BANK_IDX_W'((a >> (SRAM_ADDRESS_SIZE + 2)) & ADDR_W'(BANK_COUNT - 1));
  endfunction

  function automatic logic [SRAM_ADDRESS_SIZE-1:0] wordOf(input logic [ADDR_W-1:0] a);
    return SRAM_ADDRESS_SIZE'(a >> 2);
  endfunction

  function automatic logic outOfRange(input logic [ADDR_W-1:0] a);
    return (a >> (SRAM_ADDRESS_SIZE + 2 + BANK_W)) != '0;
  endfunction

  assign clk0 = clk;
  assign clk1 = clk;

  assign coreBank       = bankOf(coreAddress);
  assign wbBank         = bankOf(wbAddress);
  assign coreWord       = wordOf(coreAddress);
  assign wbWord         = wordOf(wbAddress);
  assign coreOutOfRange = outOfRange(coreAddress);
  assign wbOutOfRange   = outOfRange(wbAddress);

  // A requester asserting read and write together is a write
  assign coreWriteReq = rst_n & coreWriteEnable;
  assign coreReadReq  = rst_n & coreReadEnable & ~coreWriteEnable;
  assign wbReq        = rst_n & (wbWriteEnable | wbReadEnable);

  assign port0Idle = (port0State == IDLE);
  assign port1Idle = (port1State == IDLE);
  assign grantCore = port0Idle & coreWriteReq & (~wbReq | ~rrPointer);
  assign grantWb   = port0Idle & wbReq & (~coreWriteReq | rrPointer);
  assign contested = port0Idle & coreWriteReq & wbReq;

  // Core read on port 1 hitting the word being written on port 0 in the same cycle
  assign collision = coreReadReq & port1Idle & grantWb & wbWriteEnable & ~wbOutOfRange
                   & ~coreOutOfRange & (wbBank == coreBank) & (wbWord == coreWord);

`ifdef LOCAL_MEMORY_WRITE_FORWARD_EN
  assign readBlocked = 1'b0;
`else
  assign readBlocked = collision;
`endif

  assign coreBusy = ~rst_n | (coreWriteReq & ~grantCore) | (coreReadReq & port1Idle);
  assign wbBusy   = ~rst_n | (wbReq & port0Idle & (~grantWb | ~wbWriteEnable));

  // Port 0: core writes, wb reads and writes
  always_comb begin
    port0Next  = port0State;
    bank0Next  = bank0Reg;
    oor0Next   = oor0Reg;
    rrNext     = rrPointer;
    wbHeldNext = wbHeld;
    csb0       = '1;
    web0       = 1'b1;
    wmask0     = '0;
    addr0      = '0;
    din0       = '0;
    wbDataRead = wbHeld;
    if (!rst_n) begin
      wbDataRead = '0;
    end else begin
      case (port0State)
        IDLE: begin
          if (contested) rrNext = ~rrPointer;
          if (grantCore) begin
            addr0  = coreWord;
            web0   = 1'b0;
            wmask0 = coreByteSelect;
            din0   = coreDataWrite;
            if (!coreOutOfRange) csb0 = ~(BANK_COUNT'(1) << coreBank);
          end else if (grantWb) begin
            addr0 = wbWord;
            if (!wbOutOfRange) csb0 = ~(BANK_COUNT'(1) << wbBank);
            if (wbWriteEnable) begin
              web0   = 1'b0;
              wmask0 = wbByteSelect;
              din0   = wbDataWrite;
            end else begin
              port0Next = READ;
              bank0Next = wbBank;
              oor0Next  = wbOutOfRange;
            end
          end
        end
        READ: begin
          wbDataRead = oor0Reg ? '0 : dout0[DATA_W*int'(bank0Reg) +: DATA_W];
          wbHeldNext = wbDataRead;
          port0Next  = IDLE;
        end
        default: port0Next = IDLE;
      endcase
    end
  end

  // Port 1: core reads only
  always_comb begin
    port1Next    = port1State;
    bank1Next    = bank1Reg;
    oor1Next     = oor1Reg;
    coreHeldNext = coreHeld;
    csb1         = '1;
    addr1        = '0;
    coreDataRead = coreHeld;
    core1Data    = dout1[DATA_W*int'(bank1Reg) +: DATA_W];
`ifdef LOCAL_MEMORY_WRITE_FORWARD_EN
    fwdValidNext = fwdValid;
    fwdMaskNext  = fwdMask;
    fwdDataNext  = fwdData;
    for (int i = 0; i < 4; i++) begin
      if (fwdValid && fwdMask[i]) core1Data[8*i +: 8] = fwdData[8*i +: 8];
    end
`endif
    if (!rst_n) begin
      coreDataRead = '0;
    end else begin
      case (port1State)
        IDLE: begin
          if (coreReadReq && !readBlocked) begin
            addr1 = coreWord;
            if (!coreOutOfRange) csb1 = ~(BANK_COUNT'(1) << coreBank);
            port1Next = READ;
            bank1Next = coreBank;
            oor1Next  = coreOutOfRange;
`ifdef LOCAL_MEMORY_WRITE_FORWARD_EN
            fwdValidNext = collision;
            fwdMaskNext  = wbByteSelect;
            fwdDataNext  = wbDataWrite;
`endif
          end
        end
        READ: begin
          coreDataRead = oor1Reg ? '0 : core1Data;
          coreHeldNext = coreDataRead;
          port1Next    = IDLE;
        end
        default: port1Next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      port0State <= IDLE;
      port1State <= IDLE;
      rrPointer  <= 1'b0;
      bank0Reg   <= '0;
      bank1Reg   <= '0;
      oor0Reg    <= 1'b0;
      oor1Reg    <= 1'b0;
      coreHeld   <= '0;
      wbHeld     <= '0;
`ifdef LOCAL_MEMORY_WRITE_FORWARD_EN
      fwdValid   <= 1'b0;
      fwdMask    <= '0;
      fwdData    <= '0;
`endif
    end else begin
      port0State <= port0Next;
      port1State <= port1Next;
      rrPointer  <= rrNext;
      bank0Reg   <= bank0Next;
      bank1Reg   <= bank1Next;
      oor0Reg    <= oor0Next;
      oor1Reg    <= oor1Next;
      coreHeld   <= coreHeldNext;
      wbHeld     <= wbHeldNext;
`ifdef LOCAL_MEMORY_WRITE_FORWARD_EN
      fwdValid   <= fwdValidNext;
      fwdMask    <= fwdMaskNext;
      fwdData    <= fwdDataNext;
`endif
    end
  end

endmodule
